dma_register_bank: RTL and testbench

//  Channel register bank of the DMA controller; directly consumes the register-select strobes from the decoder.

---
 rtl/dma_pkg.sv | 37 +++
 rtl/dma_channel_regs.sv | 56 +++++
 rtl/dma_register_bank.sv | 128 ++++++++++++
 tb/tb_dma_register_bank.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA channel register bank.
// Pure declarations: no latency, no flow control.
package dma_pkg;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 16;
  localparam int CH_W   = $clog2(NUM_CH);

  // Status register layout: request lines above terminal-count flags
  localparam int STATUS_TC_LSB  = 0;
  localparam int STATUS_REQ_LSB = 4;

  // Mode register bit positions used by the datapath
  localparam int MODE_DEC_BIT      = 5;
  localparam int MODE_AUTOINIT_BIT = 4;

  localparam logic [ADDR_W-1:0] WORD_ONE = 1;

  typedef struct packed {
    logic [1:0] mode;
    logic       dec;
    logic       autoinit;
    logic [1:0] xfer;
    logic [1:0] ch;
  } mode_t;

  function automatic logic [ADDR_W-1:0] setByte(input logic [ADDR_W-1:0] w,
                                                input logic hi,
                                                input logic [7:0] b);
    return hi ? {b, w[7:0]} : {w[15:8], b};
  endfunction

  function automatic logic [7:0] getByte(input logic [ADDR_W-1:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/dma_channel_regs.sv
// One channel's base/current address and word count, byte writes, per-transfer update, TC detect, autoinit reload.
// Writes and updates land 1 cycle after their strobe/pulse; tcHit is combinational from the update pulse.
// No backpressure: a CPU write to a register wins over a same-cycle update of that register.
module dma_channel_regs
  import dma_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              writeAddr,
  input  logic              writeCount,
  input  logic              byteHigh,
  input  logic [7:0]        dataIn,
  input  logic              update,
  input  logic              dec,
  input  logic              autoinit,
  output logic [ADDR_W-1:0] currentAddr,
  output logic [ADDR_W-1:0] currentCount,
  output logic              tcHit
);

  logic [ADDR_W-1:0] baseAddr;
  logic [ADDR_W-1:0] baseCount;
  logic              reload;

  // TC is the 0x0000 -> 0xFFFF wrap; a colliding count write suppresses it
  assign tcHit  = update && !writeCount && (currentCount == '0);
  assign reload = tcHit && autoinit;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      baseAddr     <= '0;
      baseCount    <= '0;
      currentAddr  <= '0;
      currentCount <= '0;
    end else begin
      if (writeAddr) begin
        baseAddr    <= setByte(baseAddr, byteHigh, dataIn);
        currentAddr <= setByte(currentAddr, byteHigh, dataIn);
      end else if (reload) begin
        currentAddr <= baseAddr;
      end else if (update) begin
        currentAddr <= dec ? currentAddr - WORD_ONE : currentAddr + WORD_ONE;
      end

      if (writeCount) begin
        baseCount    <= setByte(baseCount, byteHigh, dataIn);
        currentCount <= setByte(currentCount, byteHigh, dataIn);
      end else if (reload) begin
        currentCount <= baseCount;
      end else if (update) begin
        currentCount <= currentCount - WORD_ONE;
      end
    end
  end

endmodule

// File: rtl/dma_register_bank.sv
// DMA channel register bank: strobe edge detect, byte pointer, command/mode/status, read mux; DMA_AUTOINIT_EN enables autoinit.
// Writes visible and read data valid 1 cycle after a strobe's rising edge; currentAddr is combinational.
// No backpressure: each strobe edge acts once, clearInternalFF drops a same-cycle address/count access.
module dma_register_bank
  import dma_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   loadCommandReg,
  input  logic                   loadModeReg,
  input  logic                   loadBaseAddressReg,
  input  logic                   loadBaseWordCountReg,
  input  logic                   readCurrentAddressReg,
  input  logic                   readCurrentWordCountReg,
  input  logic                   readStatusReg,
  input  logic                   clearInternalFF,
  input  logic [CH_W-1:0]        chSel,
  input  logic [7:0]             dataIn,
  input  logic [NUM_CH-1:0]      dreq,
  input  logic                   updateEn,
  input  logic [CH_W-1:0]        updateCh,
  output logic [7:0]             dataOut,
  output logic                   dataOutValid,
  output logic [ADDR_W-1:0]      currentAddr,
  output logic [7:0]             commandReg,
  output logic [NUM_CH-1:0][7:0] modeReg,
  output logic                   tcPulse
);

  logic [7:0] strobeNow;
  logic [7:0] strobeQ;
  logic cmdEdge, modeEdge, wrAddrEdge, wrCountEdge;
  logic rdAddrEdge, rdCountEdge, statusEdge, clearEdge;
  logic accessEdge, wrAddrGo, wrCountGo, rdAddrGo, rdCountGo;
  logic byteFF;
  logic [NUM_CH-1:0] tcFlags;
  logic [NUM_CH-1:0] tcHit;
  logic [7:0] statusByte;
  mode_t modeIn;
  logic [ADDR_W-1:0] chAddr  [NUM_CH];
  logic [ADDR_W-1:0] chCount [NUM_CH];

  assign strobeNow = {clearInternalFF, readStatusReg, readCurrentWordCountReg, readCurrentAddressReg,
                      loadBaseWordCountReg, loadBaseAddressReg, loadModeReg, loadCommandReg};
  assign {clearEdge, statusEdge, rdCountEdge, rdAddrEdge,
          wrCountEdge, wrAddrEdge, modeEdge, cmdEdge} = strobeNow & ~strobeQ;

  assign accessEdge = wrAddrEdge | wrCountEdge | rdAddrEdge | rdCountEdge;
  assign wrAddrGo   = wrAddrEdge  & ~clearEdge;
  assign wrCountGo  = wrCountEdge & ~clearEdge;
  assign rdAddrGo   = rdAddrEdge  & ~clearEdge;
  assign rdCountGo  = rdCountEdge & ~clearEdge;

`ifdef DMA_AUTOINIT_EN
  assign modeIn = mode_t'(dataIn);
`else
  assign modeIn = mode_t'({dataIn[7:5], 1'b0, dataIn[3:0]});
`endif

  always_comb begin
    statusByte = '0;
    statusByte[STATUS_REQ_LSB +: NUM_CH] = dreq;
    statusByte[STATUS_TC_LSB +: NUM_CH]  = tcFlags;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    dma_channel_regs uRegs (
      .CLK          (CLK),
      .RESET        (RESET),
      .writeAddr    (wrAddrGo  && (chSel == CH_W'(i))),
      .writeCount   (wrCountGo && (chSel == CH_W'(i))),
      .byteHigh     (byteFF),
      .dataIn       (dataIn),
      .update       (updateEn && (updateCh == CH_W'(i))),
      .dec          (modeReg[i][MODE_DEC_BIT]),
      .autoinit     (modeReg[i][MODE_AUTOINIT_BIT]),
      .currentAddr  (chAddr[i]),
      .currentCount (chCount[i]),
      .tcHit        (tcHit[i])
    );
  end

  assign currentAddr = chAddr[updateCh];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      strobeQ      <= '0;
      byteFF       <= 1'b0;
      commandReg   <= '0;
      modeReg      <= '0;
      tcFlags      <= '0;
      tcPulse      <= 1'b0;
      dataOut      <= '0;
      dataOutValid <= 1'b0;
    end else begin
      strobeQ <= strobeNow;
      tcPulse <= |tcHit;
      // A TC landing in the same cycle as a status read survives the clear
      tcFlags <= (statusEdge ? '0 : tcFlags) | tcHit;

      if (clearEdge) begin
        byteFF <= 1'b0;
      end else if (accessEdge) begin
        byteFF <= ~byteFF;
      end

      if (cmdEdge) begin
        commandReg <= dataIn;
      end
      if (modeEdge) begin
        modeReg[dataIn[CH_W-1:0]] <= modeIn;
      end

      dataOutValid <= 1'b0;
      if (rdAddrGo) begin
        dataOut      <= getByte(chAddr[chSel], byteFF);
        dataOutValid <= 1'b1;
      end else if (rdCountGo) begin
        dataOut      <= getByte(chCount[chSel], byteFF);
        dataOutValid <= 1'b1;
      end else if (statusEdge) begin
        dataOut      <= statusByte;
        dataOutValid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_register_bank.sv
// Directed self-checking bench for dma_register_bank; expectations follow DMA_AUTOINIT_EN when defined.
module tb_dma_register_bank;

  localparam int S_CMD    = 0;
  localparam int S_MODE   = 1;
  localparam int S_WADDR  = 2;
  localparam int S_WCOUNT = 3;
  localparam int S_RADDR  = 4;
  localparam int S_RCOUNT = 5;
  localparam int S_STATUS = 6;
  localparam int S_CLEAR  = 7;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            loadCommandReg, loadModeReg, loadBaseAddressReg, loadBaseWordCountReg;
  logic            readCurrentAddressReg, readCurrentWordCountReg, readStatusReg, clearInternalFF;
  logic [1:0]      chSel;
  logic [7:0]      dataIn;
  logic [3:0]      dreq;
  logic            updateEn;
  logic [1:0]      updateCh;
  logic [7:0]      dataOut;
  logic            dataOutValid;
  logic [15:0]     currentAddr;
  logic [7:0]      commandReg;
  logic [3:0][7:0] modeReg;
  logic            tcPulse;

  int assertCount = 0;
  int failCount   = 0;

  always #5 CLK = ~CLK;

  dma_register_bank dut (
    .CLK                     (CLK),
    .RESET                   (RESET),
    .loadCommandReg          (loadCommandReg),
    .loadModeReg             (loadModeReg),
    .loadBaseAddressReg      (loadBaseAddressReg),
    .loadBaseWordCountReg    (loadBaseWordCountReg),
    .readCurrentAddressReg   (readCurrentAddressReg),
    .readCurrentWordCountReg (readCurrentWordCountReg),
    .readStatusReg           (readStatusReg),
    .clearInternalFF         (clearInternalFF),
    .chSel                   (chSel),
    .dataIn                  (dataIn),
    .dreq                    (dreq),
    .updateEn                (updateEn),
    .updateCh                (updateCh),
    .dataOut                 (dataOut),
    .dataOutValid            (dataOutValid),
    .currentAddr             (currentAddr),
    .commandReg              (commandReg),
    .modeReg                 (modeReg),
    .tcPulse                 (tcPulse)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setStrobe(input int which, input logic v);
    case (which)
      S_CMD:    loadCommandReg          = v;
      S_MODE:   loadModeReg             = v;
      S_WADDR:  loadBaseAddressReg      = v;
      S_WCOUNT: loadBaseWordCountReg    = v;
      S_RADDR:  readCurrentAddressReg   = v;
      S_RCOUNT: readCurrentWordCountReg = v;
      S_STATUS: readStatusReg           = v;
      default:  clearInternalFF         = v;
    endcase
  endtask

  // One-cycle strobe; returns on the falling edge after the acting rising edge
  task automatic access(input int which, input logic [1:0] ch, input logic [7:0] d);
    @(negedge CLK);
    chSel  = ch;
    dataIn = d;
    setStrobe(which, 1'b1);
    @(negedge CLK);
    setStrobe(which, 1'b0);
  endtask

  task automatic readByte(input int which, input logic [1:0] ch, input string tag, input logic [7:0] exp);
    access(which, ch, 8'h00);
    checkEq(tag, dataOut, exp);
    checkEq({tag, "_vld"}, dataOutValid, 1);
    @(negedge CLK);
    checkEq({tag, "_vld_drop"}, dataOutValid, 0);
  endtask

  task automatic doUpdate(input logic [1:0] ch, input logic expTc, input string tag);
    @(negedge CLK);
    updateCh = ch;
    updateEn = 1'b1;
    @(negedge CLK);
    updateEn = 1'b0;
    checkEq(tag, tcPulse, expTc);
    @(negedge CLK);
    checkEq({tag, "_end"}, tcPulse, 0);
  endtask

  task automatic checkAddr(input logic [1:0] ch, input string tag, input logic [15:0] exp);
    updateCh = ch;
    #1;
    checkEq(tag, currentAddr, exp);
  endtask

  initial begin
    RESET = 1'b1;
    {loadCommandReg, loadModeReg, loadBaseAddressReg, loadBaseWordCountReg} = '0;
    {readCurrentAddressReg, readCurrentWordCountReg, readStatusReg, clearInternalFF} = '0;
    chSel = 0; dataIn = 0; dreq = 0; updateEn = 0; updateCh = 0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    checkEq("rst_dataOut", dataOut, 0);
    checkEq("rst_valid", dataOutValid, 0);
    checkEq("rst_tcPulse", tcPulse, 0);
    checkEq("rst_cmd", commandReg, 0);
    checkEq("rst_mode", modeReg, 0);
    checkAddr(0, "rst_addr0", 16'h0000);

    // Byte pointer order on ch1 address
    access(S_WADDR, 1, 8'h34);
    access(S_WADDR, 1, 8'h12);
    checkAddr(1, "t1_addr", 16'h1234);
    readByte(S_RADDR, 1, "t1_rd_lo", 8'h34);
    readByte(S_RADDR, 1, "t1_rd_hi", 8'h12);
    readByte(S_RADDR, 1, "t1_ff_zero", 8'h34);
    access(S_CLEAR, 0, 8'h00);

    access(S_CMD, 0, 8'hA5);
    checkEq("cmd_write", commandReg, 8'hA5);

    // Clearing the byte pointer, including a colliding write that must be dropped
    access(S_WADDR, 2, 8'h77);
    access(S_CLEAR, 0, 8'h00);
    access(S_WADDR, 2, 8'hAB);
    checkAddr(2, "t2_clear_lo", 16'h00AB);
    access(S_CLEAR, 0, 8'h00);
    @(negedge CLK);
    chSel = 2; dataIn = 8'hEE;
    loadBaseAddressReg = 1'b1; clearInternalFF = 1'b1;
    @(negedge CLK);
    loadBaseAddressReg = 1'b0; clearInternalFF = 1'b0;
    checkAddr(2, "t2_clear_wins", 16'h00AB);
    access(S_WADDR, 2, 8'hCD);
    checkAddr(2, "t2_after_clear", 16'h00CD);
    access(S_CLEAR, 0, 8'h00);

    // ch0 increment mode, count 1 -> TC on the second transfer
    access(S_MODE, 0, 8'h00);
    access(S_WADDR, 0, 8'h00);
    access(S_WADDR, 0, 8'h01);
    access(S_WCOUNT, 0, 8'h01);
    access(S_WCOUNT, 0, 8'h00);
    checkAddr(0, "t3_addr_init", 16'h0100);
    doUpdate(0, 1'b0, "t3_upd1_tc");
    checkAddr(0, "t3_addr_upd1", 16'h0101);
    doUpdate(0, 1'b1, "t3_upd2_tc");
    checkAddr(0, "t3_addr_upd2", 16'h0102);
    readByte(S_RCOUNT, 0, "t3_cnt_lo", 8'hFF);
    readByte(S_RCOUNT, 0, "t3_cnt_hi", 8'hFF);
    dreq = 4'b1010;
    readByte(S_STATUS, 0, "t3_status1", 8'hA1);
    readByte(S_STATUS, 0, "t3_status2", 8'hA0);

    // ch3 decrement + autoinit, count 0 -> immediate TC
    dreq = 4'b0000;
    access(S_MODE, 0, 8'h3B);
`ifdef DMA_AUTOINIT_EN
    checkEq("t4_mode3", modeReg[3], 8'h3B);
`else
    checkEq("t4_mode3", modeReg[3], 8'h2B);
`endif
    access(S_WADDR, 3, 8'h00);
    access(S_WADDR, 3, 8'h20);
    access(S_WCOUNT, 3, 8'h00);
    access(S_WCOUNT, 3, 8'h00);
    doUpdate(3, 1'b1, "t4_tc");
`ifdef DMA_AUTOINIT_EN
    checkAddr(3, "t4_addr", 16'h2000);
    readByte(S_RCOUNT, 3, "t4_cnt_lo", 8'h00);
    readByte(S_RCOUNT, 3, "t4_cnt_hi", 8'h00);
`else
    checkAddr(3, "t4_addr", 16'h1FFF);
    readByte(S_RCOUNT, 3, "t4_cnt_lo", 8'hFF);
    readByte(S_RCOUNT, 3, "t4_cnt_hi", 8'hFF);
`endif
    readByte(S_STATUS, 0, "t4_status", 8'h08);

    // IOW held for 5 cycles with changing data: only the first cycle may act
    @(negedge CLK);
    chSel = 2; dataIn = 8'h11; loadBaseAddressReg = 1'b1;
    for (int k = 1; k < 5; k++) begin
      @(negedge CLK);
      dataIn = 8'(8'h11 + k);
    end
    @(negedge CLK);
    loadBaseAddressReg = 1'b0;
    checkAddr(2, "t5_held_once", 16'h0011);
    access(S_WADDR, 2, 8'h22);
    checkAddr(2, "t5_ff_toggled_once", 16'h2211);

    // Write/update collision on ch0: address write wins, count still decrements
    @(negedge CLK);
    chSel = 0; dataIn = 8'h55; loadBaseAddressReg = 1'b1;
    updateCh = 0; updateEn = 1'b1;
    @(negedge CLK);
    loadBaseAddressReg = 1'b0; updateEn = 1'b0;
    access(S_CLEAR, 0, 8'h00);
    checkAddr(0, "t6_collision_addr", 16'h0155);
    readByte(S_RCOUNT, 0, "t6_cnt_lo", 8'hFE);
    readByte(S_RCOUNT, 0, "t6_cnt_hi", 8'hFF);

    // Reset in the middle of a transfer
    @(negedge CLK);
    RESET = 1'b1; updateCh = 3; updateEn = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; updateEn = 1'b0;
    checkEq("t6_rst_cmd", commandReg, 0);
    checkEq("t6_rst_mode", modeReg, 0);
    checkEq("t6_rst_tcPulse", tcPulse, 0);
    checkEq("t6_rst_dataOut", dataOut, 0);
    checkEq("t6_rst_valid", dataOutValid, 0);
    for (int c = 0; c < 4; c++) begin
      checkAddr(2'(c), $sformatf("t6_rst_addr%0d", c), 16'h0000);
    end
    readByte(S_RCOUNT, 3, "t6_rst_cnt3", 8'h00);
    dreq = 4'b0101;
    readByte(S_STATUS, 0, "t6_rst_status", 8'h50);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
